// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter time-sharing one carry-lookahead adder through a 2-stage pipeline.
// Optional feature: define ADD_ARBITER_SAT_EN to saturate rsp_sum on signed overflow.

module add_arbiter_cla #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s
);
    logic [W-1:0] p, g, pp;
    // Kogge-Stone prefix: g[i] ends up as the carry out of bits [i:0], with the carry-in folded into bit 0
    always_comb begin
        p = a ^ b;
        g = a & b;
        g[0] = g[0] | (p[0] & ci);
        pp = p;
        for (int d = 1; d < W; d = d * 2) begin
            for (int i = W - 1; i >= d; i--) begin
                g[i] = g[i] | (pp[i] & g[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        s = p ^ {g[W-2:0], ci};
    end
endmodule

module add_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_a,
    input  logic [NREQ*DW-1:0]       req_b,
    input  logic [NREQ-1:0]          req_sub,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [DW-1:0]            rsp_sum,
    output logic                     rsp_ovf
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

    occ_e            state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, gid, s1_id_q, rsp_id_q;
    logic [IW:0]     idx;
    logic [NREQ-1:0] gnt;
    logic [DW-1:0]   s1_a_q, s1_b_q, bx, sum, res, rsp_sum_q;
    logic            s1_sub_q, rsp_valid_q, rsp_ovf_q, ovf;
    logic            s1_full, s1_adv, can_acc, xfer, s1_v_d, s2_v_d;
    logic [15:0]     ops_done_q;

    // Round-robin pick: scan from the pointer upward, the lowest offset with a valid request wins
    always_comb begin
        gnt = '0;
        gid = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + (IW + 1)'(k);
            if (idx >= (IW + 1)'(NREQ)) idx = idx - (IW + 1)'(NREQ);
            if (req_valid[idx[IW-1:0]]) begin
                gnt = '0;
                gnt[idx[IW-1:0]] = 1'b1;
                gid = idx[IW-1:0];
            end
        end
    end

    // Occupancy decode: with one stage full, S2 holds it exactly when a response is presented
    always_comb begin
        s1_full   = (state_q == FULL) || ((state_q == ONE) && !rsp_valid_q);
        s1_adv    = s1_full && (!rsp_valid_q || rsp_ready);
        can_acc   = !s1_full || s1_adv;
        req_ready = (can_acc && !rst) ? gnt : '0;
        xfer      = |(req_valid & req_ready);
        s1_v_d    = xfer || (s1_full && !s1_adv);
        s2_v_d    = s1_adv || (rsp_valid_q && !rsp_ready);
        state_d   = (s1_v_d && s2_v_d) ? FULL : (s1_v_d || s2_v_d) ? ONE : EMPTY;
        ptr_d     = (gid == IW'(NREQ - 1)) ? '0 : gid + 1'b1;
    end

    assign bx = s1_b_q ^ {DW{s1_sub_q}};

    add_arbiter_cla #(.W(DW)) u_cla (
        .a  (s1_a_q),
        .b  (bx),
        .ci (s1_sub_q),
        .s  (sum)
    );

    // Signed overflow: operands agree in sign but the result does not
    always_comb begin
        ovf = (s1_a_q[DW-1] == bx[DW-1]) && (sum[DW-1] != s1_a_q[DW-1]);
`ifdef ADD_ARBITER_SAT_EN
        res = ovf ? {s1_a_q[DW-1], {(DW - 1){~s1_a_q[DW-1]}}} : sum;
`else
        res = sum;
`endif
    end

    // Occupancy FSM, round-robin pointer, both pipeline stages and the handshake counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            ptr_q       <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_sub_q    <= 1'b0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            rsp_ovf_q   <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= s2_v_d;
            if (xfer) begin
                ptr_q    <= ptr_d;
                s1_a_q   <= req_a[gid*DW +: DW];
                s1_b_q   <= req_b[gid*DW +: DW];
                s1_sub_q <= req_sub[gid];
                s1_id_q  <= gid;
            end
            if (s1_adv) begin
                rsp_sum_q <= res;
                rsp_id_q  <= s1_id_q;
                rsp_ovf_q <= ovf;
            end
            if (rsp_valid_q && rsp_ready) ops_done_q <= ops_done_q + 16'd1;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_ovf   = rsp_ovf_q;
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: randomized bench for add_arbiter against a 2-deep in-order FIFO model with minimum latency 2.
module tb_add_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_sub = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*DW-1:0] req_a = '0;
    logic [NREQ*DW-1:0] req_b = '0;
    logic              rsp_valid, rsp_ovf;
    logic              rsp_ready = 1'b1;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_sum;

    typedef struct {
        logic [15:0] sum;
        int          id;
        logic        ovf;
        int          rt;
    } ent_t;

    ent_t q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int last_gnt = NREQ - 1;
    int cyc      = 0;
    int dut_gid;
    int exp_rr[5] = '{0, 1, 2, 3, 0};

    add_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // True signed result from integer arithmetic; overflow means it does not fit in 16 bits
    function automatic ent_t ref_op(input int i, input int rt);
        ent_t e;
        int ra, rb, r;
        ra = int'($signed(req_a[i*DW +: DW]));
        rb = int'($signed(req_b[i*DW +: DW]));
        r  = req_sub[i] ? ra - rb : ra + rb;
        e.ovf = (r > 32767) || (r < -32768);
        e.sum = r[15:0];
`ifdef ADD_ARBITER_SAT_EN
        if (e.ovf) e.sum = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        e.id = i;
        e.rt = rt;
        return e;
    endfunction

    // One clock cycle: compare outputs mid-cycle with the model, then advance the model across the edge
    task automatic tick();
        logic vis;
        logic [NREQ-1:0] eg;
        ent_t e;
        @(negedge clk);
        vis = (q.size() > 0) && (q[0].rt <= cyc);
        check("rsp_valid", rsp_valid, vis);
        if (vis) begin
            check("rsp_sum", rsp_sum, q[0].sum);
            check("rsp_id", rsp_id, q[0].id);
            check("rsp_ovf", rsp_ovf, q[0].ovf);
        end
        eg = '0;
        if (q.size() < 2 || (vis && rsp_ready)) begin
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (last_gnt + k) % NREQ;
                if (eg == '0 && req_valid[i]) eg[i] = 1'b1;
            end
        end
        check("req_ready", req_ready, eg);
        dut_gid = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_gid = i;
        if (vis && rsp_ready) begin
            void'(q.pop_front());
            if (q.size() > 0 && q[0].rt < cyc + 1) begin
                e = q[0];
                e.rt = cyc + 1;
                q[0] = e;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (eg[i]) begin
                q.push_back(ref_op(i, cyc + 2));
                last_gnt = i;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic randomize_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*DW +: DW] = pick_operand();
            req_b[i*DW +: DW] = pick_operand();
            req_sub[i] = 1'($urandom);
        end
    endtask

    task automatic single(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic [15:0] exp_sum, input logic exp_ovf, input string tag);
        req_valid = 4'b0001;
        req_a[0 +: DW] = a;
        req_b[0 +: DW] = b;
        req_sub[0] = sub;
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        tick();
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_sum"}, rsp_sum, exp_sum);
        check({tag, "_id"}, rsp_id, 2'd0);
        check({tag, "_ovf"}, rsp_ovf, exp_ovf);
        tick();
        tick();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_ready", req_ready, 4'b0000);
        check("rst_sum", rsp_sum, 16'h0000);
        check("rst_id", rsp_id, 2'd0);
        check("rst_ovf", rsp_ovf, 1'b0);
        q.delete();
        last_gnt = NREQ - 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        req_valid = '1;
        #1;
        do_reset();

        randomize_ops();
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_grant", dut_gid, exp_rr[k]);
        end
        req_valid = '0;
        repeat (3) tick();

        single(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, "single");
`ifdef ADD_ARBITER_SAT_EN
        single(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1, "ovf");
`else
        single(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, "ovf");
`endif
        single(16'h0005, 16'h0008, 1'b1, 16'hFFFD, 1'b0, "sub");

        randomize_ops();
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (3) tick();
        rsp_ready = 1'b0;
        repeat (4) begin
            tick();
            check("bp_no_grant", dut_gid, -1);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();

        for (int n = 0; n < 400; n++) begin
            randomize_ops();
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        randomize_ops();
        req_valid = '1;
        rsp_ready = 1'b0;
        repeat (3) tick();
        do_reset();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();
        for (int n = 0; n < 50; n++) begin
            randomize_ops();
            req_valid = NREQ'($urandom);
            rsp_ready = 1'($urandom);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
